alu_operand_stage: RTL and testbench
====================================

Name: alu_operand_stage

Overview:
Registered ID/EX operand-select stage for the MIPS pipeline. It is the generalised successor of the combinational ALU source mux.
- Selects ALU operand 1 and operand 2 from register data, extended immediate, shift amount, or link address.
- Applies EX/MEM and MEM/WB forwarding before selection.
- Registers the result into the EX stage, with stall (hold) and flush (bubble) control.
- Parametrised in data width and shift-amount width.

Parameters:
WORD_SIZE, 32, datapath width in bits
REG_ADDR_W, 5, register-file address width
SHAMT_W, 5, shift-amount width; must be <= WORD_SIZE

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
stall  input  1  hold all output registers
flush  input  1  insert bubble next cycle
in_valid  input  1  ID-stage instruction valid
AluSrc  input  3  operand mode select
rs_addr  input  REG_ADDR_W  rs register number
rt_addr  input  REG_ADDR_W  rt register number
regfile_read_data1  input  WORD_SIZE  rs value from register file
regfile_read_data2  input  WORD_SIZE  rt value from register file
ext_immidiate  input  WORD_SIZE  sign/zero-extended immediate
shamt  input  SHAMT_W  instruction shift field
pc_plus8  input  WORD_SIZE  link address
exmem_wr_en  input  1  EX/MEM stage writes a register
exmem_wr_addr  input  REG_ADDR_W  EX/MEM destination register
exmem_wr_data  input  WORD_SIZE  EX/MEM result
memwb_wr_en  input  1  MEM/WB stage writes a register
memwb_wr_addr  input  REG_ADDR_W  MEM/WB destination register
memwb_wr_data  input  WORD_SIZE  MEM/WB result
out_valid  output  1  EX-stage operands valid
alu_src_out1  output  WORD_SIZE  registered ALU operand 1
alu_src_out2  output  WORD_SIZE  registered ALU operand 2
fwd_a  output  2  registered forward source for rs: 00 regfile, 01 MEM/WB, 10 EX/MEM
fwd_b  output  2  registered forward source for rt, same encoding as fwd_a

Behaviour:
- Reset: asynchronous on rst high. out_valid=0, alu_src_out1=0, alu_src_out2=0, fwd_a=00, fwd_b=00. Registers stay cleared while rst is high.
- Forwarding (combinational, before selection), shown for rs; rt is identical using rt_addr, regfile_read_data2, fwd_b:
  - Condition "EX/MEM hit": exmem_wr_en=1, exmem_wr_addr==rs_addr, rs_addr!=0.
  - Condition "MEM/WB hit": memwb_wr_en=1, memwb_wr_addr==rs_addr, rs_addr!=0.
  - EX/MEM hit: rs value = exmem_wr_data, fwd_a=10.
  - Otherwise MEM/WB hit: rs value = memwb_wr_data, fwd_a=01.
  - Otherwise: rs value = regfile_read_data1, fwd_a=00.
  - EX/MEM wins when both stages hit.
  - Register 0 is never forwarded.
- Operand select (uses the forwarded values; rs' and rt' below):
  - 000 R-type: op1=rs', op2=rt'.
  - 001 I-type: op1=rs', op2=ext_immidiate.
  - 010 link: op1=pc_plus8, op2=0.
  - 011 constant shift: op1=rt', op2=zero-extended shamt.
  - 100 variable shift: op1=rt', op2=zero-extended rs'[SHAMT_W-1:0].
  - 101 upper immediate: op1=0, op2=ext_immidiate.
  - 110, 111: treated exactly as 000. No latch is inferred for any code.
- Register update, each rising edge, in priority order:
  1. flush=1 (overrides stall): out_valid=0, both operands=0, fwd_a=00, fwd_b=00.
  2. Else stall=1: all outputs hold their previous values. Forwarded data is not re-sampled.
  3. Else: out_valid=in_valid; operands and fwd_a/fwd_b load the selected values.
- in_valid=0 without flush: operands still load. Only out_valid marks the bubble.
- Latency: exactly 1 cycle from ID inputs to registered outputs.
- Reset asserted mid-stall or mid-flush clears immediately. The first non-stalled edge after reset release loads normally.

Test Plan:
- Reset: rst=1 while other inputs toggle -> all outputs 0 and out_valid=0; first edge after release with AluSrc=000, rd1=5, rd2=7, in_valid=1 -> out1=5, out2=7, out_valid=1.
- Forward priority: rs_addr=3, exmem hit with data 0xAAAA, memwb hit with data 0xBBBB, AluSrc=001, imm=4 -> out1=0xAAAA, out2=4, fwd_a=10; with exmem_wr_en=0 -> out1=0xBBBB, fwd_a=01.
- Zero register: rs_addr=rt_addr=0, exmem writes reg 0 with 0xFFFF, rd1=rd2=0 -> out1=out2=0, fwd_a=fwd_b=00.
- Shift modes: AluSrc=011, shamt=31, rt'=0x80 -> out1=0x80, out2=31. AluSrc=100, rs'=0x12345677 -> out2=0x17 (low 5 bits of rs').
- Stall/flush: load out1=9; stall=1 for 3 cycles while inputs change -> out1 stays 9. Then stall=1 and flush=1 together -> out_valid=0, outputs 0 next edge.
- Mode coverage: AluSrc=010, pc_plus8=0x408 -> out1=0x408, out2=0. AluSrc=101, imm=0x12340000 -> out1=0, out2=0x12340000. AluSrc=111 -> same result as 000.

Source files
------------

// File: rtl/alu_operand_stage.sv
// ID/EX operand-select stage: forwards rs/rt from EX/MEM or MEM/WB, picks ALU
// operands by AluSrc, and registers them into EX with stall/flush control.
module alu_operand_stage #(
   parameter int WORD_SIZE  = 32,
   parameter int REG_ADDR_W = 5,
   parameter int SHAMT_W    = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  in_valid,
   input  logic [2:0]            AluSrc,
   input  logic [REG_ADDR_W-1:0] rs_addr,
   input  logic [REG_ADDR_W-1:0] rt_addr,
   input  logic [WORD_SIZE-1:0]  regfile_read_data1,
   input  logic [WORD_SIZE-1:0]  regfile_read_data2,
   input  logic [WORD_SIZE-1:0]  ext_immidiate,
   input  logic [SHAMT_W-1:0]    shamt,
   input  logic [WORD_SIZE-1:0]  pc_plus8,
   input  logic                  exmem_wr_en,
   input  logic [REG_ADDR_W-1:0] exmem_wr_addr,
   input  logic [WORD_SIZE-1:0]  exmem_wr_data,
   input  logic                  memwb_wr_en,
   input  logic [REG_ADDR_W-1:0] memwb_wr_addr,
   input  logic [WORD_SIZE-1:0]  memwb_wr_data,
   output logic                  out_valid,
   output logic [WORD_SIZE-1:0]  alu_src_out1,
   output logic [WORD_SIZE-1:0]  alu_src_out2,
   output logic [1:0]            fwd_a,
   output logic [1:0]            fwd_b
);

   localparam logic [1:0] FWD_RF    = 2'b00;
   localparam logic [1:0] FWD_MEMWB = 2'b01;
   localparam logic [1:0] FWD_EXMEM = 2'b10;

   localparam logic [2:0] SRC_RTYPE = 3'b000;
   localparam logic [2:0] SRC_ITYPE = 3'b001;
   localparam logic [2:0] SRC_LINK  = 3'b010;
   localparam logic [2:0] SRC_SHC   = 3'b011;
   localparam logic [2:0] SRC_SHV   = 3'b100;
   localparam logic [2:0] SRC_LUI   = 3'b101;

   logic                 valid_q, valid_d;
   logic [WORD_SIZE-1:0] op1_q, op1_d;
   logic [WORD_SIZE-1:0] op2_q, op2_d;
   logic [1:0]           fwd_a_q, fwd_a_d;
   logic [1:0]           fwd_b_q, fwd_b_d;

   logic [WORD_SIZE-1:0] rs_val, rt_val;
   logic [1:0]           fwd_a_sel, fwd_b_sel;
   logic [WORD_SIZE-1:0] shamt_ext, rs_shamt_ext;
   logic [WORD_SIZE-1:0] sel1, sel2;

   // Register 0 is hard-wired zero, so a write to it is never a forwarding hit.
   always_comb begin
      rs_val    = regfile_read_data1;
      fwd_a_sel = FWD_RF;
      if (exmem_wr_en && (exmem_wr_addr == rs_addr) && (rs_addr != '0)) begin
         rs_val    = exmem_wr_data;
         fwd_a_sel = FWD_EXMEM;
      end else if (memwb_wr_en && (memwb_wr_addr == rs_addr) && (rs_addr != '0)) begin
         rs_val    = memwb_wr_data;
         fwd_a_sel = FWD_MEMWB;
      end
   end

   always_comb begin
      rt_val    = regfile_read_data2;
      fwd_b_sel = FWD_RF;
      if (exmem_wr_en && (exmem_wr_addr == rt_addr) && (rt_addr != '0)) begin
         rt_val    = exmem_wr_data;
         fwd_b_sel = FWD_EXMEM;
      end else if (memwb_wr_en && (memwb_wr_addr == rt_addr) && (rt_addr != '0)) begin
         rt_val    = memwb_wr_data;
         fwd_b_sel = FWD_MEMWB;
      end
   end

   // Zero-extension written as a partial overwrite so SHAMT_W == WORD_SIZE stays legal.
   always_comb begin
      shamt_ext                  = '0;
      shamt_ext[SHAMT_W-1:0]     = shamt;
      rs_shamt_ext               = '0;
      rs_shamt_ext[SHAMT_W-1:0]  = rs_val[SHAMT_W-1:0];
   end

   always_comb begin
      sel1 = rs_val;
      sel2 = rt_val;
      case (AluSrc)
         SRC_RTYPE: begin sel1 = rs_val;   sel2 = rt_val;        end
         SRC_ITYPE: begin sel1 = rs_val;   sel2 = ext_immidiate; end
         SRC_LINK:  begin sel1 = pc_plus8; sel2 = '0;            end
         SRC_SHC:   begin sel1 = rt_val;   sel2 = shamt_ext;     end
         SRC_SHV:   begin sel1 = rt_val;   sel2 = rs_shamt_ext;  end
         SRC_LUI:   begin sel1 = '0;       sel2 = ext_immidiate; end
         default:   begin sel1 = rs_val;   sel2 = rt_val;        end
      endcase
   end

   // out_valid qualifies the EX operands; there is no ready, stall is the
   // back-pressure and flush (higher priority) turns the next slot into a bubble.
   always_comb begin
      valid_d = valid_q;
      op1_d   = op1_q;
      op2_d   = op2_q;
      fwd_a_d = fwd_a_q;
      fwd_b_d = fwd_b_q;
      if (flush) begin
         valid_d = 1'b0;
         op1_d   = '0;
         op2_d   = '0;
         fwd_a_d = FWD_RF;
         fwd_b_d = FWD_RF;
      end else if (!stall) begin
         valid_d = in_valid;
         op1_d   = sel1;
         op2_d   = sel2;
         fwd_a_d = fwd_a_sel;
         fwd_b_d = fwd_b_sel;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         op1_q   <= '0;
         op2_q   <= '0;
         fwd_a_q <= FWD_RF;
         fwd_b_q <= FWD_RF;
      end else begin
         valid_q <= valid_d;
         op1_q   <= op1_d;
         op2_q   <= op2_d;
         fwd_a_q <= fwd_a_d;
         fwd_b_q <= fwd_b_d;
      end
   end

   assign out_valid    = valid_q;
   assign alu_src_out1 = op1_q;
   assign alu_src_out2 = op2_q;
   assign fwd_a        = fwd_a_q;
   assign fwd_b        = fwd_b_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: one task per feature, hand-computed
// expectations, single summary line at the end.
module tb_alu_operand_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall, flush, in_valid;
   logic [2:0]  AluSrc;
   logic [4:0]  rs_addr, rt_addr;
   logic [31:0] regfile_read_data1, regfile_read_data2, ext_immidiate, pc_plus8;
   logic [4:0]  shamt;
   logic        exmem_wr_en, memwb_wr_en;
   logic [4:0]  exmem_wr_addr, memwb_wr_addr;
   logic [31:0] exmem_wr_data, memwb_wr_data;
   logic        out_valid;
   logic [31:0] alu_src_out1, alu_src_out2;
   logic [1:0]  fwd_a, fwd_b;

   int checks = 0;
   int failures = 0;
   logic [31:0] ref1, ref2;

   always #5 clk = ~clk;

   alu_operand_stage #(.WORD_SIZE(32), .REG_ADDR_W(5), .SHAMT_W(5)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
      .AluSrc(AluSrc), .rs_addr(rs_addr), .rt_addr(rt_addr),
      .regfile_read_data1(regfile_read_data1), .regfile_read_data2(regfile_read_data2),
      .ext_immidiate(ext_immidiate), .shamt(shamt), .pc_plus8(pc_plus8),
      .exmem_wr_en(exmem_wr_en), .exmem_wr_addr(exmem_wr_addr), .exmem_wr_data(exmem_wr_data),
      .memwb_wr_en(memwb_wr_en), .memwb_wr_addr(memwb_wr_addr), .memwb_wr_data(memwb_wr_data),
      .out_valid(out_valid), .alu_src_out1(alu_src_out1), .alu_src_out2(alu_src_out2),
      .fwd_a(fwd_a), .fwd_b(fwd_b)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_defaults();
      stall = 0; flush = 0; in_valid = 1; AluSrc = 3'b000;
      rs_addr = 5'd1; rt_addr = 5'd2;
      regfile_read_data1 = 32'h0; regfile_read_data2 = 32'h0;
      ext_immidiate = 32'h0; shamt = 5'd0; pc_plus8 = 32'h0;
      exmem_wr_en = 0; exmem_wr_addr = 5'd0; exmem_wr_data = 32'h0;
      memwb_wr_en = 0; memwb_wr_addr = 5'd0; memwb_wr_data = 32'h0;
   endtask

   task automatic test_reset();
      set_defaults();
      rst = 1;
      for (int i = 0; i < 3; i++) begin
         regfile_read_data1 = 32'h100 + i; regfile_read_data2 = 32'h200 + i;
         AluSrc = 3'(i); in_valid = i[0];
         tick();
      end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
      checks++; if (alu_src_out1 !== 32'h0) begin failures++; $display("FAIL reset_out1 got=%h exp=0", alu_src_out1); end
      checks++; if (alu_src_out2 !== 32'h0) begin failures++; $display("FAIL reset_out2 got=%h exp=0", alu_src_out2); end
      checks++; if ({fwd_a, fwd_b} !== 4'b0000) begin failures++; $display("FAIL reset_fwd got=%b%b exp=0000", fwd_a, fwd_b); end
      set_defaults();
      rst = 0;
      regfile_read_data1 = 32'd5; regfile_read_data2 = 32'd7;
      tick();
      checks++; if (alu_src_out1 !== 32'd5) begin failures++; $display("FAIL post_reset_out1 got=%h exp=5", alu_src_out1); end
      checks++; if (alu_src_out2 !== 32'd7) begin failures++; $display("FAIL post_reset_out2 got=%h exp=7", alu_src_out2); end
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL post_reset_valid got=%0b exp=1", out_valid); end
   endtask

   task automatic test_forward_priority();
      set_defaults();
      rs_addr = 5'd3; rt_addr = 5'd4; AluSrc = 3'b001; ext_immidiate = 32'd4;
      regfile_read_data1 = 32'h1111; regfile_read_data2 = 32'h2222;
      exmem_wr_en = 1; exmem_wr_addr = 5'd3; exmem_wr_data = 32'hAAAA;
      memwb_wr_en = 1; memwb_wr_addr = 5'd3; memwb_wr_data = 32'hBBBB;
      tick();
      checks++; if (alu_src_out1 !== 32'hAAAA) begin failures++; $display("FAIL fwd_exmem_out1 got=%h exp=0000aaaa", alu_src_out1); end
      checks++; if (alu_src_out2 !== 32'd4) begin failures++; $display("FAIL fwd_exmem_out2 got=%h exp=4", alu_src_out2); end
      checks++; if (fwd_a !== 2'b10) begin failures++; $display("FAIL fwd_exmem_fwd_a got=%b exp=10", fwd_a); end
      checks++; if (fwd_b !== 2'b00) begin failures++; $display("FAIL fwd_exmem_fwd_b got=%b exp=00", fwd_b); end
      exmem_wr_en = 0;
      tick();
      checks++; if (alu_src_out1 !== 32'hBBBB) begin failures++; $display("FAIL fwd_memwb_out1 got=%h exp=0000bbbb", alu_src_out1); end
      checks++; if (fwd_a !== 2'b01) begin failures++; $display("FAIL fwd_memwb_fwd_a got=%b exp=01", fwd_a); end
      // rt path: EX/MEM hit on rt, MEM/WB hit on rs with different register
      AluSrc = 3'b000; rs_addr = 5'd6; rt_addr = 5'd3;
      exmem_wr_en = 1; memwb_wr_addr = 5'd6;
      tick();
      checks++; if (alu_src_out1 !== 32'hBBBB) begin failures++; $display("FAIL fwd_rs_memwb_out1 got=%h exp=0000bbbb", alu_src_out1); end
      checks++; if (alu_src_out2 !== 32'hAAAA) begin failures++; $display("FAIL fwd_rt_exmem_out2 got=%h exp=0000aaaa", alu_src_out2); end
      checks++; if ({fwd_a, fwd_b} !== 4'b0110) begin failures++; $display("FAIL fwd_ab got=%b%b exp=0110", fwd_a, fwd_b); end
   endtask

   task automatic test_zero_reg();
      set_defaults();
      rs_addr = 5'd0; rt_addr = 5'd0;
      exmem_wr_en = 1; exmem_wr_addr = 5'd0; exmem_wr_data = 32'hFFFF;
      memwb_wr_en = 1; memwb_wr_addr = 5'd0; memwb_wr_data = 32'hEEEE;
      tick();
      checks++; if (alu_src_out1 !== 32'h0) begin failures++; $display("FAIL zero_out1 got=%h exp=0", alu_src_out1); end
      checks++; if (alu_src_out2 !== 32'h0) begin failures++; $display("FAIL zero_out2 got=%h exp=0", alu_src_out2); end
      checks++; if ({fwd_a, fwd_b} !== 4'b0000) begin failures++; $display("FAIL zero_fwd got=%b%b exp=0000", fwd_a, fwd_b); end
   endtask

   task automatic test_shift();
      set_defaults();
      AluSrc = 3'b011; shamt = 5'd31; regfile_read_data2 = 32'h80; regfile_read_data1 = 32'h12345677;
      tick();
      checks++; if (alu_src_out1 !== 32'h80) begin failures++; $display("FAIL shc_out1 got=%h exp=80", alu_src_out1); end
      checks++; if (alu_src_out2 !== 32'd31) begin failures++; $display("FAIL shc_out2 got=%h exp=1f", alu_src_out2); end
      AluSrc = 3'b100;
      tick();
      checks++; if (alu_src_out1 !== 32'h80) begin failures++; $display("FAIL shv_out1 got=%h exp=80", alu_src_out1); end
      checks++; if (alu_src_out2 !== 32'h17) begin failures++; $display("FAIL shv_out2 got=%h exp=17", alu_src_out2); end
      // variable shift amount taken from the forwarded rs value
      exmem_wr_en = 1; exmem_wr_addr = 5'd1; exmem_wr_data = 32'hFFFF_FFE3;
      tick();
      checks++; if (alu_src_out2 !== 32'h03) begin failures++; $display("FAIL shv_fwd_out2 got=%h exp=3", alu_src_out2); end
   endtask

   task automatic test_stall_flush();
      set_defaults();
      regfile_read_data1 = 32'd9; regfile_read_data2 = 32'd1;
      tick();
      checks++; if (alu_src_out1 !== 32'd9) begin failures++; $display("FAIL stall_load_out1 got=%h exp=9", alu_src_out1); end
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         regfile_read_data1 = 32'd20 + i; in_valid = 0;
         exmem_wr_en = 1; exmem_wr_addr = 5'd1; exmem_wr_data = 32'h55;
         tick();
         checks++; if (alu_src_out1 !== 32'd9) begin failures++; $display("FAIL stall_hold_out1 cyc=%0d got=%h exp=9", i, alu_src_out1); end
         checks++; if ({out_valid, fwd_a} !== 3'b100) begin failures++; $display("FAIL stall_hold_vf cyc=%0d got=%b exp=100", i, {out_valid, fwd_a}); end
      end
      flush = 1;
      tick();
      checks++; if ({out_valid, fwd_a, fwd_b} !== 5'b0) begin failures++; $display("FAIL flush_vf got=%b exp=00000", {out_valid, fwd_a, fwd_b}); end
      checks++; if ({alu_src_out1, alu_src_out2} !== 64'h0) begin failures++; $display("FAIL flush_ops got=%h_%h exp=0_0", alu_src_out1, alu_src_out2); end
      // bubble without flush: operands still load
      set_defaults();
      in_valid = 0; regfile_read_data1 = 32'h33; regfile_read_data2 = 32'h44;
      tick();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bubble_valid got=%0b exp=0", out_valid); end
      checks++; if (alu_src_out1 !== 32'h33) begin failures++; $display("FAIL bubble_out1 got=%h exp=33", alu_src_out1); end
   endtask

   task automatic test_modes();
      set_defaults();
      AluSrc = 3'b010; pc_plus8 = 32'h408; regfile_read_data1 = 32'hDEAD; regfile_read_data2 = 32'hBEEF;
      tick();
      checks++; if ({alu_src_out1, alu_src_out2} !== {32'h408, 32'h0}) begin failures++; $display("FAIL link got=%h_%h exp=408_0", alu_src_out1, alu_src_out2); end
      AluSrc = 3'b101; ext_immidiate = 32'h12340000;
      tick();
      checks++; if ({alu_src_out1, alu_src_out2} !== {32'h0, 32'h12340000}) begin failures++; $display("FAIL lui got=%h_%h exp=0_12340000", alu_src_out1, alu_src_out2); end
      for (int i = 6; i < 8; i++) begin
         AluSrc = 3'(i);
         tick();
         checks++; if ({alu_src_out1, alu_src_out2} !== {32'hDEAD, 32'hBEEF}) begin failures++; $display("FAIL mode%0d_as_rtype got=%h_%h exp=dead_beef", i, alu_src_out1, alu_src_out2); end
      end
   endtask

   task automatic test_reset_mid_stall();
      set_defaults();
      regfile_read_data1 = 32'h77; regfile_read_data2 = 32'h88;
      tick();
      stall = 1;
      #2 rst = 1;
      #1;
      checks++; if ({out_valid, alu_src_out1, alu_src_out2} !== 65'h0) begin failures++; $display("FAIL async_reset got=%b_%h_%h exp=0", out_valid, alu_src_out1, alu_src_out2); end
      tick();
      rst = 0; stall = 0;
      regfile_read_data1 = 32'h99; regfile_read_data2 = 32'hAB;
      tick();
      checks++; if ({out_valid, alu_src_out1, alu_src_out2} !== {1'b1, 32'h99, 32'hAB}) begin failures++; $display("FAIL reset_release_load got=%b_%h_%h exp=1_99_ab", out_valid, alu_src_out1, alu_src_out2); end
   endtask

   initial begin
      test_reset();
      test_forward_priority();
      test_zero_reg();
      test_shift();
      test_stall_flush();
      test_modes();
      test_reset_mid_stall();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
